// File: rtl/counter_3_bit_monitor_if.sv
// counter_3_bit_monitor_if: count bus from the counter plus the monitor's status outputs
interface counter_3_bit_monitor_if #(
  parameter int CNT_W  = 3,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic [CNT_W-1:0]  count;
  logic              locked;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              step_err;
  logic [ERR_W-1:0]  err_cnt;
  logic              err_sticky;
  modport master (output count, input locked, wrap_pulse, wrap_cnt, step_err, err_cnt, err_sticky);
  modport slave  (input count, output locked, wrap_pulse, wrap_cnt, step_err, err_cnt, err_sticky);
endinterface

// File: rtl/counter_3_bit_monitor.sv
// counter_3_bit_monitor: checks a free-running count bus steps by +1 and reports wraps, errors and lock
module counter_3_bit_monitor #(
  parameter int CNT_W  = 3,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 4
) (
  input logic clk,
  input logic reset,
  counter_3_bit_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  state_t state;
  logic [CNT_W-1:0] prev;
  logic [3:0] good_run;
  logic legal, wrap;
  always_comb begin
    legal = bus.count == CNT_W'(prev + 1'b1);
    wrap  = legal && (&prev);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      prev           <= '0;
      good_run       <= '0;
      bus.locked     <= 1'b0;
      bus.wrap_pulse <= 1'b0;
      bus.wrap_cnt   <= '0;
      bus.step_err   <= 1'b0;
      bus.err_cnt    <= '0;
      bus.err_sticky <= 1'b0;
    end else begin
      prev           <= bus.count;
      bus.wrap_pulse <= 1'b0;
      bus.step_err   <= 1'b0;
      if (state == IDLE) begin
        good_run <= '0;
        state    <= ACQ;
      end else if (legal) begin
        bus.wrap_pulse <= wrap;
        if (wrap && !(&bus.wrap_cnt)) bus.wrap_cnt <= bus.wrap_cnt + 1'b1;
        if (state == ACQ) begin
          good_run <= good_run + 4'd1;
          if (good_run + 4'd1 == 4'(LOCK_N)) begin
            state      <= TRACK;
            bus.locked <= 1'b1;
          end
        end
      end else begin
        // prev already resyncs to the bad sample, so only this one step is flagged
        bus.step_err   <= 1'b1;
        bus.err_sticky <= 1'b1;
        if (!(&bus.err_cnt)) bus.err_cnt <= bus.err_cnt + 1'b1;
        good_run       <= '0;
        bus.locked     <= 1'b0;
        state          <= ACQ;
      end
    end
  end
endmodule

// File: tb/tb_counter_3_bit_monitor.sv
// tb_counter_3_bit_monitor: directed vector table plus hand-written reset and saturation sequences
module tb_counter_3_bit_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  counter_3_bit_monitor_if bus ();
  counter_3_bit_monitor_if #(.WRAP_W(2)) bus2 ();
  counter_3_bit_monitor dut (.clk(clk), .reset(reset), .bus(bus.slave));
  counter_3_bit_monitor #(.WRAP_W(2)) dut2 (.clk(clk), .reset(reset2), .bus(bus2.slave));
  typedef struct {
    logic       rst;
    logic [2:0] cnt;
    logic       lk;
    logic       wp;
    int         wc;
    logic       se;
    int         ec;
    logic       st;
  } vec_t;
  vec_t tbl[33];
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [2:0] c);
    reset = r;
    bus.count = c;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(input string tag, input logic lk, input logic wp, input int wc,
                           input logic se, input int ec, input logic st);
    check({tag, " locked"}, int'(bus.locked), int'(lk));
    check({tag, " wrap_pulse"}, int'(bus.wrap_pulse), int'(wp));
    check({tag, " wrap_cnt"}, int'(bus.wrap_cnt), wc);
    check({tag, " step_err"}, int'(bus.step_err), int'(se));
    check({tag, " err_cnt"}, int'(bus.err_cnt), ec);
    check({tag, " err_sticky"}, int'(bus.err_sticky), int'(st));
  endtask
  initial begin
    int wraps;
    bus.count = '0;
    bus2.count = '0;
    // rst cnt locked wrap_pulse wrap_cnt step_err err_cnt err_sticky
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 2, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 3, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 4, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 5, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 6, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 7, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 2, 1, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 3, 1, 0, 1, 0, 0, 0};
    tbl[13] = '{0, 5, 0, 0, 1, 1, 1, 1};
    tbl[14] = '{0, 6, 0, 0, 1, 0, 1, 1};
    tbl[15] = '{0, 7, 0, 0, 1, 0, 1, 1};
    tbl[16] = '{0, 0, 0, 1, 2, 0, 1, 1};
    tbl[17] = '{0, 1, 1, 0, 2, 0, 1, 1};
    tbl[18] = '{0, 2, 1, 0, 2, 0, 1, 1};
    tbl[19] = '{0, 3, 1, 0, 2, 0, 1, 1};
    tbl[20] = '{0, 4, 1, 0, 2, 0, 1, 1};
    tbl[21] = '{0, 4, 0, 0, 2, 1, 2, 1};
    tbl[22] = '{0, 5, 0, 0, 2, 0, 2, 1};
    tbl[23] = '{0, 6, 0, 0, 2, 0, 2, 1};
    tbl[24] = '{0, 7, 0, 0, 2, 0, 2, 1};
    tbl[25] = '{0, 0, 1, 1, 3, 0, 2, 1};
    tbl[26] = '{0, 1, 1, 0, 3, 0, 2, 1};
    tbl[27] = '{0, 2, 1, 0, 3, 0, 2, 1};
    tbl[28] = '{0, 3, 1, 0, 3, 0, 2, 1};
    tbl[29] = '{0, 4, 1, 0, 3, 0, 2, 1};
    tbl[30] = '{0, 5, 1, 0, 3, 0, 2, 1};
    tbl[31] = '{0, 0, 0, 0, 3, 1, 3, 1};
    tbl[32] = '{0, 1, 0, 0, 3, 0, 3, 1};
    for (int i = 0; i < 33; i++) begin
      cyc(tbl[i].rst, tbl[i].cnt);
      check_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].wp, tbl[i].wc, tbl[i].se, tbl[i].ec, tbl[i].st);
    end
    // free-run 17, reset 1 cycle, free-run 10
    cyc(1'b1, 3'd0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 3'(i));
    cyc(1'b1, 3'd0);
    check_all("midrst", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 3'(i));
    check_all("rerun", 1, 0, 1, 0, 0, 0);
    // reset coincides with an illegal sample; next sample after release is absorbed by IDLE
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'(i + 2));
    cyc(1'b1, 3'd7);
    check_all("rst_err", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 3'd6);
    check_all("idle_abs", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 3'd7);
    check_all("post_idle", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 3'd0);
    check_all("post_wrap", 0, 1, 1, 0, 0, 0);
    // narrow wrap counter saturates while wrap_pulse keeps firing
    reset2 = 1'b1;
    bus2.count = '0;
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      bus2.count = 3'(i);
      @(posedge clk);
      #1;
      if (i > 0 && i % 8 == 0) wraps++;
      check($sformatf("sat%0d wrap_pulse", i), int'(bus2.wrap_pulse), int'(i > 0 && i % 8 == 0));
      check($sformatf("sat%0d wrap_cnt", i), int'(bus2.wrap_cnt), wraps > 3 ? 3 : wraps);
    end
    check("sat step_err", int'(bus2.err_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
